stack_unit: RTL and testbench

//  Parametrised hardware stack engine for the 16-bit core. Replaces the ad-hoc SP register and SP mux pair.

---
 rtl/stack_pkg.sv | 10 +
 rtl/stack_ram.sv | 26 ++
 rtl/stack_unit.sv | 114 +++++++++++
 tb/tb_stack_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the hardware stack engine.
// Op-code encodings used on the op_code request field.
package stack_pkg;

    localparam logic [1:0] OP_PEEK    = 2'b00;
    localparam logic [1:0] OP_PUSH    = 2'b01;
    localparam logic [1:0] OP_POP     = 2'b10;
    localparam logic [1:0] OP_REPLACE = 2'b11;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x DATA_W, one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module stack_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// Stack engine: owns the stack pointer, entry count, storage and a 1-entry response register.
// Accepts PEEK/PUSH/POP/REPLACE over valid/ready; read responses support backpressure.
module stack_unit
    import stack_pkg::*;
#(
    parameter int              DATA_W = 16,
    parameter int              ADDR_W = 16,
    parameter int              DEPTH  = 32,
    parameter logic [ADDR_W-1:0] BASE = 16'hFFFE,
    parameter int              STEP   = 2,
    localparam int             CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [DATA_W-1:0] push_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] sp,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              overflow_err,
    output logic              underflow_err,
    input  logic              err_clr
);

    localparam int              AW     = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

    logic              accept;
    logic              is_push;
    logic              is_read;
    logic              do_push;
    logic              do_pop;
    logic              do_repl;
    logic              ovf_set;
    logic              unf_set;
    logic [AW-1:0]     top_addr;
    logic [AW-1:0]     next_addr;
    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [DATA_W-1:0] top_data;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A held response blocks new ops; a consumed one frees the slot in the same cycle.
    assign op_ready = !rsp_valid || rsp_ready;
    assign accept   = op_valid && op_ready;

    assign is_push = (op_code == OP_PUSH);
    assign is_read = !is_push;
    assign do_push = accept && is_push && !full;
    assign do_pop  = accept && (op_code == OP_POP) && !empty;
    assign do_repl = accept && (op_code == OP_REPLACE) && !empty;
    assign ovf_set = accept && is_push && full;
    assign unf_set = accept && is_read && empty;

    assign top_addr  = AW'(count - CW'(1));
    assign next_addr = AW'(count);
    assign ram_we    = !reset && (do_push || do_repl);
    assign ram_waddr = do_push ? next_addr : top_addr;

    stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (push_data),
        .raddr (top_addr),
        .rdata (top_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            count         <= '0;
            sp            <= BASE;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (do_push) begin
                count <= count + CW'(1);
                sp    <= sp - STEP_V;
            end else if (do_pop) begin
                count <= count - CW'(1);
                sp    <= sp + STEP_V;
            end

            if (accept && is_read) begin
                rsp_valid <= 1'b1;
                rsp_data  <= empty ? '0 : top_data;
                rsp_err   <= empty;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            // Set wins over a simultaneous clear.
            overflow_err  <= (overflow_err && !err_clr) || ovf_set;
            underflow_err <= (underflow_err && !err_clr) || unf_set;
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: directed ops push expected responses, a monitor pops and
// compares on every response handshake.
module tb_stack_unit;
    import stack_pkg::*;

    localparam int DEPTH = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_code;
    logic [15:0] push_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [15:0] sp;
    logic [CW-1:0] count;
    logic        full;
    logic        empty;
    logic        overflow_err;
    logic        underflow_err;
    logic        err_clr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [16:0] sb_q[$];

    always #5 clk = ~clk;

    stack_unit #(
        .DATA_W (16),
        .ADDR_W (16),
        .DEPTH  (DEPTH),
        .BASE   (16'hFFFE),
        .STEP   (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_code       (op_code),
        .push_data     (push_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .sp            (sp),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err),
        .err_clr       (err_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Response monitor: compares at the negedge before each handshake edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_data), 32'hFFFF_FFFF);
                end else begin
                    logic [16:0] e;
                    e = sb_q.pop_front();
                    check("rsp_data", 32'(rsp_data), 32'(e[15:0]));
                    check("rsp_err", 32'(rsp_err), 32'(e[16]));
                end
            end
        end
    end

    task automatic issue(input logic [1:0] code, input logic [15:0] d,
                         input logic [15:0] exp_d, input logic exp_e);
        int n;
        op_valid  = 1'b1;
        op_code   = code;
        push_data = d;
        if (code != OP_PUSH) sb_q.push_back({exp_e, exp_d});
        n = 0;
        @(negedge clk);
        while (!op_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("op_ready_wait", 32'(op_ready), 32'd1);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset     = 1'b1;
        op_valid  = 1'b0;
        op_code   = OP_PEEK;
        push_data = '0;
        rsp_ready = 1'b1;
        err_clr   = 1'b0;
        idle(2);
        reset = 1'b0;

        check("rst_sp", 32'(sp), 32'hFFFE);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_flags", 32'({overflow_err, underflow_err}), 32'd0);

        // LIFO order and sp movement
        issue(OP_PUSH, 16'h00A1, 16'h0, 1'b0);
        issue(OP_PUSH, 16'h00B2, 16'h0, 1'b0);
        issue(OP_PUSH, 16'h00C3, 16'h0, 1'b0);
        check("t1_sp_after_push", 32'(sp), 32'hFFF8);
        check("t1_count", 32'(count), 32'd3);
        issue(OP_POP, 16'h0, 16'h00C3, 1'b0);
        issue(OP_POP, 16'h0, 16'h00B2, 1'b0);
        issue(OP_POP, 16'h0, 16'h00A1, 1'b0);
        check("t1_sp_end", 32'(sp), 32'hFFFE);
        check("t1_empty", 32'(empty), 32'd1);
        idle(1);

        // Fill, overflow, peek top, drain
        for (int i = 0; i < DEPTH; i++) issue(OP_PUSH, 16'h0100 + 16'(i), 16'h0, 1'b0);
        check("t2_full", 32'(full), 32'd1);
        check("t2_ovf_before", 32'(overflow_err), 32'd0);
        issue(OP_PUSH, 16'hDEAD, 16'h0, 1'b0);
        check("t2_overflow", 32'(overflow_err), 32'd1);
        check("t2_count", 32'(count), 32'd32);
        check("t2_sp", 32'(sp), 32'hFFBE);
        issue(OP_PEEK, 16'h0, 16'h011F, 1'b0);
        for (int i = 0; i < DEPTH; i++) issue(OP_POP, 16'h0, 16'h011F - 16'(i), 1'b0);
        check("t2_empty", 32'(empty), 32'd1);

        // Underflow, set-wins with err_clr, then clear
        issue(OP_POP, 16'h0, 16'h0000, 1'b1);
        check("t3_underflow", 32'(underflow_err), 32'd1);
        check("t3_sp", 32'(sp), 32'hFFFE);
        err_clr = 1'b1;
        issue(OP_PEEK, 16'h0, 16'h0000, 1'b1);
        err_clr = 1'b0;
        check("t3_set_wins", 32'(underflow_err), 32'd1);
        check("t3_ovf_cleared", 32'(overflow_err), 32'd0);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("t3_unf_cleared", 32'(underflow_err), 32'd0);

        // Backpressure hold, then release together with a POP
        issue(OP_PUSH, 16'h0055, 16'h0, 1'b0);
        rsp_ready = 1'b0;
        issue(OP_PEEK, 16'h0, 16'h0055, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_op_ready_low", 32'(op_ready), 32'd0);
            check("t4_rsp_held", 32'({rsp_valid, rsp_data}), 32'h1_0055);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        issue(OP_POP, 16'h0, 16'h0055, 1'b0);
        @(negedge clk);
        check("t4_no_bubble", 32'(rsp_valid), 32'd1);
        check("t4_count", 32'(count), 32'd0);
        idle(1);

        // Replace
        issue(OP_PUSH, 16'h1111, 16'h0, 1'b0);
        issue(OP_REPLACE, 16'h2222, 16'h1111, 1'b0);
        check("t5_count", 32'(count), 32'd1);
        issue(OP_POP, 16'h0, 16'h2222, 1'b0);
        check("t5_empty", 32'(empty), 32'd1);
        idle(1);

        // Reset with a PUSH presented
        issue(OP_POP, 16'h0, 16'h0000, 1'b1);
        issue(OP_PUSH, 16'h0001, 16'h0, 1'b0);
        issue(OP_PUSH, 16'h0002, 16'h0, 1'b0);
        issue(OP_PUSH, 16'h0003, 16'h0, 1'b0);
        check("t6_count_pre", 32'(count), 32'd3);
        reset     = 1'b1;
        op_valid  = 1'b1;
        op_code   = OP_PUSH;
        push_data = 16'h0BAD;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        op_valid = 1'b0;
        check("t6_count", 32'(count), 32'd0);
        check("t6_sp", 32'(sp), 32'hFFFE);
        check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_flags", 32'({overflow_err, underflow_err}), 32'd0);

        idle(3);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
